// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch engine.
//   sw_state_e  : control FSM states
//   SSEG_TABLE  : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   sseg_decode : BCD nibble to segment pattern, non-BCD codes blank
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } sw_state_e;

    localparam int unsigned SSEG_W = 7;

    localparam logic [SSEG_W-1:0] SSEG_BLANK = 7'b1111111;

    // Entry [d] is the pattern for digit d.
    localparam logic [9:0][SSEG_W-1:0] SSEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [SSEG_W-1:0] sseg_decode(input logic [3:0] bcd);
        logic [SSEG_W-1:0] seg;
        if (bcd > 4'd9) begin
            seg = SSEG_BLANK;
        end else begin
            seg = SSEG_TABLE[bcd];
        end
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_to_sseg.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i  : 4-bit BCD digit
//   sseg_o : active-low segments {g,f,e,d,c,b,a}; codes 10-15 blank
module bcd_to_sseg
    import stopwatch_pkg::*;
(
    input  logic [3:0]        bcd_i,
    output logic [SSEG_W-1:0] sseg_o
);

    always_comb begin
        sseg_o = sseg_decode(bcd_i);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch engine: run/pause/clear/lap control, N-digit BCD elapsed-time
// counter and multiplexed 7-segment scan driver.
//   clk, rst_n     : clock, async active-low reset
//   i_start_stop   : pulse, toggles run/pause
//   i_clear        : pulse, zeroes the stopwatch when not running
//   i_lap          : pulse, toggles lap freeze while running
//   o_bcd          : displayed value, packed BCD, digit 0 in [3:0]
//   o_running      : high in RUN
//   o_lap_active   : display frozen on lap value
//   o_overflow     : sticky, count passed all-nines
//   o_sseg         : active-low segments {g..a} of the scanned digit
//   o_seg_an       : active-low one-hot digit enable
//   o_dp           : active-low decimal point
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DP_POS     = 2,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start_stop,
    input  logic                    i_clear,
    input  logic                    i_lap,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_running,
    output logic                    o_lap_active,
    output logic                    o_overflow,
    output logic [SSEG_W-1:0]       o_sseg,
    output logic [NUM_DIGITS-1:0]   o_seg_an,
    output logic                    o_dp
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic        DP_RST = (DP_POS == 0) ? 1'b0 : 1'b1;

    sw_state_e             state_q, state_d;
    logic [BCD_W-1:0]      count_q, count_d;
    logic [BCD_W-1:0]      lap_q, lap_d;
    logic                  lap_active_q, lap_active_d;
    logic                  overflow_q, overflow_d;
    logic                  running_q, running_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [SSEG_W-1:0]     sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0] seg_an_q, seg_an_d;
    logic                  dp_q, dp_d;

    logic [BCD_W-1:0]      count_inc;
    logic                  carry;
    logic                  all_nines;
    logic                  tick_fire;
    logic                  clear_req;
    logic [3:0]            scan_digit;

    // Decimal increment with ripple carry; carry out means count was all-nines.
    always_comb begin
        carry     = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // Control FSM, tick prescaler, count and lap register.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        tick_d       = tick_q;

        tick_fire = (state_q == ST_RUN) && (tick_q == TICK_W'(TICK_DIV - 1));
        clear_req = i_clear && (state_q != ST_RUN);

        unique case (state_q)
            ST_IDLE: begin
                if (i_start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tick_d = tick_fire ? '0 : tick_q + TICK_W'(1);
                // A pause pulse swallows a coincident lap pulse.
                if (i_start_stop) begin
                    state_d = ST_PAUSED;
                end else if (i_lap) begin
                    if (lap_active_q) begin
                        lap_active_d = 1'b0;
                    end else begin
                        lap_d        = count_q;
                        lap_active_d = 1'b1;
                    end
                end
                if (tick_fire) begin
                    if (all_nines) begin
                        overflow_d = 1'b1;
                        if (SATURATE != 0) begin
                            state_d = ST_PAUSED;
                        end else begin
                            count_d = count_inc;
                        end
                    end else begin
                        count_d = count_inc;
                    end
                end
            end
            ST_PAUSED: begin
                if (i_clear) begin
                    state_d = ST_IDLE;
                end else if (i_start_stop) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_req) begin
            count_d      = '0;
            tick_d       = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end

        running_d = (state_d == ST_RUN);
        bcd_d     = lap_active_q ? lap_q : count_q;
    end

    // Digit scan; segments/anode/dp are computed from next-state values so the
    // registered trio always describes o_bcd at the current o_seg_an digit.
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        scan_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_d == IDX_W'(i)) begin
                scan_digit = bcd_d[4*i +: 4];
            end
        end

        seg_an_d = ~(NUM_DIGITS'(1) << scan_idx_d);
        dp_d     = (32'(scan_idx_d) == DP_POS) ? 1'b0 : 1'b1;
    end

    bcd_to_sseg u_bcd_to_sseg (
        .bcd_i  (scan_digit),
        .sseg_o (sseg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            running_q    <= 1'b0;
            tick_q       <= '0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
            bcd_q        <= '0;
            sseg_q       <= SSEG_TABLE[0];
            seg_an_q     <= ~NUM_DIGITS'(1);
            dp_q         <= DP_RST;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            running_q    <= running_d;
            tick_q       <= tick_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            bcd_q        <= bcd_d;
            sseg_q       <= sseg_d;
            seg_an_q     <= seg_an_d;
            dp_q         <= dp_d;
        end
    end

    assign o_bcd        = bcd_q;
    assign o_running    = running_q;
    assign o_lap_active = lap_active_q;
    assign o_overflow   = overflow_q;
    assign o_sseg       = sseg_q;
    assign o_seg_an     = seg_an_q;
    assign o_dp         = dp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_7 = 7'b1111000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, clr, lap;
    logic [7:0] bcd;
    logic       running, lap_act, ovf;
    logic [6:0] sseg;
    logic [1:0] an;
    logic       dp;

    logic       s_start, s_clr, s_lap;
    logic [7:0] s_bcd;
    logic       s_running, s_lap_act, s_ovf;
    logic [6:0] s_sseg;
    logic [1:0] s_an;
    logic       s_dp;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int rel_edge = 0;
    int ovf_e0 = 0;

    typedef struct {
        int          due;
        logic [10:0] v;   // {bcd, running, lap_active, overflow}
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV(4), .NUM_DIGITS(2), .SCAN_DIV(2), .DP_POS(1), .SATURATE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start_stop(start), .i_clear(clr), .i_lap(lap),
        .o_bcd(bcd), .o_running(running), .o_lap_active(lap_act), .o_overflow(ovf),
        .o_sseg(sseg), .o_seg_an(an), .o_dp(dp)
    );

    stopwatch_ctrl #(
        .TICK_DIV(4), .NUM_DIGITS(2), .SCAN_DIV(2), .DP_POS(1), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i_start_stop(s_start), .i_clear(s_clr), .i_lap(s_lap),
        .o_bcd(s_bcd), .o_running(s_running), .o_lap_active(s_lap_act), .o_overflow(s_ovf),
        .o_sseg(s_sseg), .o_seg_an(s_an), .o_dp(s_dp)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic test_reset();
        logic [1:0] exp_an;
        logic       exp_dp;
        repeat (2) step();
        checks++;
        if ({bcd, running, lap_act, ovf} !== 11'h0) begin
            errors++;
            $display("FAIL reset_status: got bcd=%h run=%b lap=%b ovf=%b, want all 0", bcd, running, lap_act, ovf);
        end
        checks++;
        if ({an, dp, sseg} !== {2'b10, 1'b1, SEG_0}) begin
            errors++;
            $display("FAIL reset_display: got an=%b dp=%b sseg=%b, want an=10 dp=1 sseg=%b", an, dp, sseg, SEG_0);
        end
        checks++;
        if ({s_bcd, s_running, s_ovf} !== 10'h0) begin
            errors++;
            $display("FAIL reset_sat: got bcd=%h run=%b ovf=%b, want 0", s_bcd, s_running, s_ovf);
        end
        rst_n = 1'b1;
        rel_edge = edges;
        for (int c = 1; c <= 8; c++) begin
            sb.push_back('{edges + 1, {8'h00, 1'b0, 1'b0, 1'b0}});
            step();
            exp_an = (((c / 2) % 2) == 0) ? 2'b10 : 2'b01;
            exp_dp = (exp_an == 2'b01) ? 1'b0 : 1'b1;
            checks++;
            if ({an, dp, sseg} !== {exp_an, exp_dp, SEG_0}) begin
                errors++;
                $display("FAIL scan edge %0d: got an=%b dp=%b sseg=%b, want an=%b dp=%b sseg=%b",
                         c, an, dp, sseg, exp_an, exp_dp, SEG_0);
            end
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL idle_after_reset edge %0d: got %h/%b%b%b want %h/%b%b%b", edges,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_count();
        logic [7:0] eb;
        logic       er;
        for (int c = 0; c <= 44; c++) begin
            start = (c == 0) || (c == 42);
            clr   = (c == 43);
            if (c == 0)       eb = 8'h00;
            else if (c <= 42) eb = to_bcd((c - 1) / 4);
            else if (c == 43) eb = 8'h10;
            else              eb = 8'h00;
            er = (c < 42);
            sb.push_back('{edges + 1, {eb, er, 1'b0, 1'b0}});
            step();
            start = 1'b0;
            clr   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL count c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [7:0] eb;
        logic       er;
        for (int c = 0; c <= 22; c++) begin
            start = (c == 0) || (c == 6) || (c == 12) || (c == 20);
            clr   = (c == 21);
            if (c == 0)       eb = 8'h00;
            else if (c <= 5)  eb = to_bcd((c - 1) / 4);
            else if (c <= 14) eb = 8'h01;
            else if (c <= 18) eb = 8'h02;
            else if (c <= 21) eb = 8'h03;
            else              eb = 8'h00;
            er = (c <= 5) || (c >= 12 && c <= 19);
            sb.push_back('{edges + 1, {eb, er, 1'b0, 1'b0}});
            step();
            start = 1'b0;
            clr   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL pause_resume c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_lap();
        logic [7:0] eb;
        logic       er, el;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        for (int c = 0; c <= 48; c++) begin
            start = (c == 0) || (c == 46);
            lap   = (c == 30) || (c == 42);
            clr   = (c == 35) || (c == 47);
            if (c == 0)       eb = 8'h00;
            else if (c <= 29) eb = to_bcd((c - 1) / 4);
            else if (c <= 42) eb = 8'h07;
            else if (c <= 44) eb = 8'h10;
            else if (c <= 47) eb = 8'h11;
            else              eb = 8'h00;
            er = (c <= 45);
            el = (c >= 30) && (c <= 41);
            sb.push_back('{edges + 1, {eb, er, el, 1'b0}});
            step();
            start = 1'b0;
            lap   = 1'b0;
            clr   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL lap c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            if (c >= 31 && c <= 41) begin
                exp_an  = ((((edges - rel_edge) / 2) % 2) == 0) ? 2'b10 : 2'b01;
                exp_seg = (exp_an == 2'b10) ? SEG_7 : SEG_0;
                checks++;
                if ({an, sseg} !== {exp_an, exp_seg}) begin
                    errors++;
                    $display("FAIL lap_segments c=%0d: got an=%b sseg=%b, want an=%b sseg=%b",
                             c, an, sseg, exp_an, exp_seg);
                end
            end
        end
    endtask

    task automatic test_start_lap();
        logic [7:0] eb;
        logic       er;
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0) || (c == 6);
            lap   = (c == 6) || (c == 9);
            clr   = (c == 12);
            if (c == 0)       eb = 8'h00;
            else if (c <= 5)  eb = to_bcd((c - 1) / 4);
            else if (c <= 12) eb = 8'h01;
            else              eb = 8'h00;
            er = (c <= 5);
            sb.push_back('{edges + 1, {eb, er, 1'b0, 1'b0}});
            step();
            start = 1'b0;
            lap   = 1'b0;
            clr   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL start_lap c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] eb;
        ovf_e0 = edges + 1;
        for (int c = 0; c <= 405; c++) begin
            start   = (c == 0);
            s_start = (c == 0);
            eb = (c == 0) ? 8'h00 : to_bcd(((c - 1) / 4) % 100);
            sb.push_back('{edges + 1, {eb, 1'b1, 1'b0, (c >= 400) ? 1'b1 : 1'b0}});
            step();
            start   = 1'b0;
            s_start = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL wrap c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            if (c == 399) begin
                checks++;
                if ({s_bcd, s_running, s_ovf} !== {8'h99, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL saturate_pre: got bcd=%h run=%b ovf=%b, want 99/1/0", s_bcd, s_running, s_ovf);
                end
            end else if (c >= 400) begin
                checks++;
                if ({s_bcd, s_running, s_ovf} !== {8'h99, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL saturate_hold c=%0d: got bcd=%h run=%b ovf=%b, want 99/0/1",
                             c, s_bcd, s_running, s_ovf);
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [7:0] eb;
        logic       er, eo;
        for (int c = edges - ovf_e0 + 1; c <= 509; c++) begin
            start = (c == 502) || (c == 506);
            clr   = (c == 506);
            if (c <= 502)      eb = to_bcd(((c - 1) / 4) % 100);
            else if (c <= 506) eb = 8'h25;
            else               eb = 8'h00;
            er = (c < 502);
            eo = (c < 506);
            sb.push_back('{edges + 1, {eb, er, 1'b0, eo}});
            step();
            start = 1'b0;
            clr   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL clear_priority c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] eb;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0);
            lap   = (c == 10);
            eb = (c == 0) ? 8'h00 : ((c <= 9) ? to_bcd((c - 1) / 4) : 8'h02);
            sb.push_back('{edges + 1, {eb, 1'b1, (c >= 10) ? 1'b1 : 1'b0, 1'b0}});
            step();
            start = 1'b0;
            lap   = 1'b0;
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL pre_reset c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bcd, running, lap_act, ovf} !== 11'h0) begin
            errors++;
            $display("FAIL async_reset_status: got bcd=%h run=%b lap=%b ovf=%b, want all 0", bcd, running, lap_act, ovf);
        end
        checks++;
        if ({an, dp, sseg} !== {2'b10, 1'b1, SEG_0}) begin
            errors++;
            $display("FAIL async_reset_display: got an=%b dp=%b sseg=%b, want an=10 dp=1 sseg=%b", an, dp, sseg, SEG_0);
        end
        checks++;
        if ({s_bcd, s_running, s_ovf} !== 10'h0) begin
            errors++;
            $display("FAIL async_reset_sat: got bcd=%h run=%b ovf=%b, want 0", s_bcd, s_running, s_ovf);
        end
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            sb.push_back('{edges + 1, {8'h00, 1'b0, 1'b0, 1'b0}});
            step();
            while (sb.size() > 0 && sb[0].due == edges) begin
                e = sb.pop_front();
                checks++;
                if ({bcd, running, lap_act, ovf} !== e.v) begin
                    errors++;
                    $display("FAIL post_reset c=%0d: got %h/%b%b%b want %h/%b%b%b", c,
                             bcd, running, lap_act, ovf, e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    initial begin
        start   = 1'b0;
        clr     = 1'b0;
        lap     = 1'b0;
        s_start = 1'b0;
        s_clr   = 1'b0;
        s_lap   = 1'b0;
        rst_n   = 1'b1;
        #2;
        rst_n   = 1'b0;
        test_reset();
        test_count();
        test_pause_resume();
        test_lap();
        test_start_lap();
        test_overflow();
        test_clear_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
